n_queen_solver: RTL

//  Parametrised N-queens backtracking solver; successor to the fixed 8-queen block.

---
 rtl/n_queen_solver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/n_queen_solver.sv
// Parametrised N-queens backtracking solver: one try/backtrack step per clock,
// solutions streamed as N row indices over a valid/ready port.
module n_queen_solver #(
  parameter  int N  = 8,
  parameter  int CW = 20,
  localparam int RW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic          clk,
  input  logic          user_reset_n,
  input  logic          start,
  input  logic          find_all,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] out_bus,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [CW-1:0] sol_count
);
  localparam int DW = 2*N-1;

  typedef enum logic [2:0] {S_IDLE, S_PLACE, S_BACK, S_EMIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [RW-1:0]           c_q, c_d, k_q, k_d;
  logic [RW:0]             r_q, r_d;
  logic [N-1:0][RW-1:0]    pos_q, pos_d;
  logic [N-1:0]            row_used_q, row_used_d;
  logic [DW-1:0]           diag_a_q, diag_a_d, diag_b_q, diag_b_d;
  logic                    find_all_q, find_all_d;
  logic [CW-1:0]           sol_count_q, sol_count_d;

  logic [N-1:0]  cur_row_m, prv_row_m;
  logic [DW-1:0] cur_da_m, cur_db_m, prv_da_m, prv_db_m;
  logic [RW-1:0] prv_r, emit_bus;
  logic          safe;

  // One-hot masks for the candidate (r,c) and for the queen being lifted at c-1
  always_comb begin
    cur_row_m = '0; prv_row_m = '0;
    cur_da_m  = '0; cur_db_m  = '0;
    prv_da_m  = '0; prv_db_m  = '0;
    prv_r     = '0; emit_bus  = '0;
    for (int j = 0; j < N; j++) begin
      if (j == int'(c_q) - 1) prv_r = pos_q[j];
      if (j == int'(k_q))     emit_bus = pos_q[j];
    end
    for (int i = 0; i < N; i++) begin
      cur_row_m[i] = (int'(r_q) == i);
      prv_row_m[i] = (int'(prv_r) == i);
    end
    for (int i = 0; i < DW; i++) begin
      cur_da_m[i] = (int'(r_q) + int'(c_q) == i);
      cur_db_m[i] = (int'(r_q) - int'(c_q) + N - 1 == i);
      prv_da_m[i] = (int'(prv_r) + int'(c_q) - 1 == i);
      prv_db_m[i] = (int'(prv_r) - int'(c_q) + 1 + N - 1 == i);
    end
    safe = ~|(row_used_q & cur_row_m) & ~|(diag_a_q & cur_da_m) & ~|(diag_b_q & cur_db_m);
  end

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    r_d         = r_q;
    k_d         = k_q;
    pos_d       = pos_q;
    row_used_d  = row_used_q;
    diag_a_d    = diag_a_q;
    diag_b_d    = diag_b_q;
    find_all_d  = find_all_q;
    sol_count_d = sol_count_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        find_all_d  = find_all;
        sol_count_d = '0;
        row_used_d  = '0;
        diag_a_d    = '0;
        diag_b_d    = '0;
        c_d         = '0;
        r_d         = '0;
        state_d     = S_PLACE;
      end
      S_PLACE: begin
        if (int'(r_q) == N) state_d = S_BACK;
        else if (!safe)     r_d = r_q + 1'b1;
        else begin
          for (int j = 0; j < N; j++)
            if (j == int'(c_q)) pos_d[j] = r_q[RW-1:0];
          if (int'(c_q) == N-1) begin
            // last column is never marked: the next try resumes right here
            if (sol_count_q != {CW{1'b1}}) sol_count_d = sol_count_q + 1'b1;
            k_d     = '0;
            state_d = S_EMIT;
          end else begin
            row_used_d = row_used_q | cur_row_m;
            diag_a_d   = diag_a_q | cur_da_m;
            diag_b_d   = diag_b_q | cur_db_m;
            c_d        = c_q + 1'b1;
            r_d        = '0;
          end
        end
      end
      S_BACK: begin
        if (c_q == '0) state_d = S_DONE;
        else begin
          row_used_d = row_used_q & ~prv_row_m;
          diag_a_d   = diag_a_q & ~prv_da_m;
          diag_b_d   = diag_b_q & ~prv_db_m;
          c_d        = c_q - 1'b1;
          r_d        = {1'b0, prv_r} + 1'b1;
          state_d    = S_PLACE;
        end
      end
      S_EMIT: if (out_ready) begin
        if (int'(k_q) == N-1) begin
          if (find_all_q) begin
            c_d     = RW'(N-1);
            r_d     = {1'b0, pos_q[N-1]} + 1'b1;
            state_d = S_PLACE;
          end else state_d = S_DONE;
        end else k_d = k_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q     <= S_IDLE;
      c_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      pos_q       <= '0;
      row_used_q  <= '0;
      diag_a_q    <= '0;
      diag_b_q    <= '0;
      find_all_q  <= 1'b0;
      sol_count_q <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      r_q         <= r_d;
      k_q         <= k_d;
      pos_q       <= pos_d;
      row_used_q  <= row_used_d;
      diag_a_q    <= diag_a_d;
      diag_b_q    <= diag_b_d;
      find_all_q  <= find_all_d;
      sol_count_q <= sol_count_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q == S_PLACE) || (state_q == S_BACK) || (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);
  assign out_valid = (state_q == S_EMIT);
  assign out_last  = out_valid && (int'(k_q) == N-1);
  assign out_bus   = out_valid ? emit_bus : '0;
  assign sol_count = sol_count_q;
endmodule
